// File: rtl/dmem_responder.sv
// Data-memory responder for the mem-stage load/store interface: one access at a time,
// a fixed number of wait states, then a single-cycle ready pulse with read data or error.
module dmem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_enable,
    input  logic        mem_write_enable,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data_in,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_data_out,
    output logic        mem_ready,
    output logic        mem_error,
    output logic        busy
);
    localparam int          AW         = $clog2(DEPTH);
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);
    localparam logic [3:0]  WAIT_LOAD  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        error_q, error_d;
    logic [31:0] dout_q, dout_d;

    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        rd_q, wr_q;

    logic [31:0] mem_q [DEPTH];

    logic          in_idle, accept, commit;
    logic [31:0]   eff_addr, eff_wdata;
    logic [3:0]    eff_wstrb;
    logic          eff_rd, eff_wr, eff_err;
    logic [AW-1:0] eff_idx;

    function automatic logic req_error(input logic [31:0] a, input logic r, input logic w);
        return (a[1:0] != 2'b00) || (a >= ADDR_LIMIT) || (r && w);
    endfunction

    // With zero wait states the commit edge is the acceptance edge, so the live
    // request inputs feed the commit path while idle; otherwise the captured copy does.
    always_comb begin
        in_idle   = (state_q == S_IDLE);
        eff_addr  = in_idle ? mem_addr         : addr_q;
        eff_wdata = in_idle ? mem_data_in      : wdata_q;
        eff_wstrb = in_idle ? mem_wstrb        : wstrb_q;
        eff_rd    = in_idle ? mem_read_enable  : rd_q;
        eff_wr    = in_idle ? mem_write_enable : wr_q;
        eff_idx   = eff_addr[AW+1:2];
        eff_err   = req_error(eff_addr, eff_rd, eff_wr);
        accept    = in_idle && (mem_read_enable || mem_write_enable);
        commit    = (accept && (WAIT_CYCLES == 0)) || ((state_q == S_WAIT) && (cnt_q == 4'd0));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    cnt_d   = WAIT_LOAD;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        error_d = error_q;
        dout_d  = dout_q;
        if (commit) begin
            error_d = eff_err;
            if (eff_err)     dout_d = 32'd0;
            else if (eff_rd) dout_d = mem_q[eff_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            error_q <= 1'b0;
            dout_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
            dout_q  <= dout_d;
        end
    end

    // Request capture needs no reset: it is only consulted outside IDLE.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_data_in;
            wstrb_q <= mem_wstrb;
            rd_q    <= mem_read_enable;
            wr_q    <= mem_write_enable;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && commit && eff_wr && !eff_err) begin
            for (int k = 0; k < 4; k++) begin
                if (eff_wstrb[k]) mem_q[eff_idx][8*k +: 8] <= eff_wdata[8*k +: 8];
            end
        end
    end

    assign mem_ready    = (state_q == S_RESP);
    assign mem_error    = mem_ready && error_q;
    assign busy         = (state_q != S_IDLE);
    assign mem_data_out = dout_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 0, 1 and 4 wait states.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        rd   [3];
    logic        wr   [3];
    logic [31:0] ad   [3];
    logic [31:0] di   [3];
    logic [3:0]  st   [3];
    logic [31:0] dout [3];
    logic        rdy  [3];
    logic        err  [3];
    logic        bsy  [3];

    int vec = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WC = (g == 0) ? 0 : ((g == 1) ? 1 : 4);
        dmem_responder #(.DEPTH(64), .WAIT_CYCLES(WC)) u_dut (
            .clk(clk), .reset(reset),
            .mem_read_enable(rd[g]), .mem_write_enable(wr[g]),
            .mem_addr(ad[g]), .mem_data_in(di[g]), .mem_wstrb(st[g]),
            .mem_data_out(dout[g]), .mem_ready(rdy[g]), .mem_error(err[g]), .busy(bsy[g])
        );
    end

    function automatic int wc_of(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 4);
    endfunction

    // Drives one request while idle, waits for ready, deasserts in the response cycle.
    task automatic access(input int i, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          output int lat, output logic [31:0] q, output logic e);
        @(negedge clk);
        rd[i] = r; wr[i] = w; ad[i] = a; di[i] = d; st[i] = s;
        lat = 0; q = 32'd0; e = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (rdy[i]) begin
                lat = n; q = dout[i]; e = err[i];
                break;
            end
        end
        rd[i] = 1'b0; wr[i] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            vec++; if (rdy[i] !== 1'b0) begin miscompares++; $display("FAIL reset_ready[%0d] got %b want 0", i, rdy[i]); end
            vec++; if (err[i] !== 1'b0) begin miscompares++; $display("FAIL reset_error[%0d] got %b want 0", i, err[i]); end
            vec++; if (bsy[i] !== 1'b0) begin miscompares++; $display("FAIL reset_busy[%0d] got %b want 0", i, bsy[i]); end
            vec++; if (dout[i] !== 32'd0) begin miscompares++; $display("FAIL reset_dout[%0d] got %h want 0", i, dout[i]); end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_latency(input int i);
        int lat; logic [31:0] q; logic e;
        access(i, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, q, e);
        vec++; if (lat !== wc_of(i) + 1) begin miscompares++; $display("FAIL wr_latency[%0d] got %0d want %0d", i, lat, wc_of(i) + 1); end
        vec++; if (e !== 1'b0) begin miscompares++; $display("FAIL wr_error[%0d] got %b want 0", i, e); end
        access(i, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, lat, q, e);
        vec++; if (lat !== wc_of(i) + 1) begin miscompares++; $display("FAIL rd_latency[%0d] got %0d want %0d", i, lat, wc_of(i) + 1); end
        vec++; if (q !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_data[%0d] got %h want deadbeef", i, q); end
    endtask

    task automatic test_strobes();
        int lat; logic [31:0] q; logic e;
        access(1, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, lat, q, e);
        access(1, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, q, e);
        access(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, q, e);
        vec++; if (q !== 32'h11BB33DD) begin miscompares++; $display("FAIL strobe_merge got %h want 11bb33dd", q); end
        access(1, 1'b0, 1'b1, 32'h20, 32'h99999999, 4'b0000, lat, q, e);
        vec++; if (e !== 1'b0) begin miscompares++; $display("FAIL noop_write_error got %b want 0", e); end
        vec++; if (q !== 32'h11BB33DD) begin miscompares++; $display("FAIL write_keeps_dout got %h want 11bb33dd", q); end
        access(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, q, e);
        vec++; if (q !== 32'h11BB33DD) begin miscompares++; $display("FAIL noop_write_data got %h want 11bb33dd", q); end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] q; logic e;
        access(1, 1'b0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, lat, q, e);
        access(1, 1'b1, 1'b0, 32'h13, 32'h0, 4'h0, lat, q, e);
        vec++; if (e !== 1'b1) begin miscompares++; $display("FAIL misalign_error got %b want 1", e); end
        vec++; if (q !== 32'd0) begin miscompares++; $display("FAIL misalign_dout got %h want 0", q); end
        access(1, 1'b0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, lat, q, e);
        vec++; if (e !== 1'b1) begin miscompares++; $display("FAIL range_error got %b want 1", e); end
        access(1, 1'b1, 1'b1, 32'h0, 32'h12121212, 4'hF, lat, q, e);
        vec++; if (e !== 1'b1) begin miscompares++; $display("FAIL rdwr_error got %b want 1", e); end
        vec++; if (lat !== 2) begin miscompares++; $display("FAIL rdwr_latency got %0d want 2", lat); end
        access(1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, q, e);
        vec++; if (q !== 32'h0BADF00D) begin miscompares++; $display("FAIL word0_intact got %h want 0badf00d", q); end
        vec++; if (e !== 1'b0) begin miscompares++; $display("FAIL word0_error got %b want 0", e); end
    endtask

    task automatic test_back_to_back(input int i);
        int lat; logic [31:0] q; logic e;
        int t [2]; logic [31:0] dv [2]; int seen;
        access(i, 1'b0, 1'b1, 32'h30, 32'hB2B00000 | 32'(i), 4'hF, lat, q, e);
        access(i, 1'b0, 1'b1, 32'h34, 32'hB2B10000 | 32'(i), 4'hF, lat, q, e);
        t[0] = 0; t[1] = 0; dv[0] = 32'd0; dv[1] = 32'd0; seen = 0;
        @(negedge clk);
        rd[i] = 1'b1; ad[i] = 32'h30;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (rdy[i]) begin
                t[seen] = c; dv[seen] = dout[i]; seen++;
                if (seen == 1) ad[i] = 32'h34;
                else begin rd[i] = 1'b0; break; end
            end
        end
        rd[i] = 1'b0;
        @(negedge clk);
        vec++; if (t[0] !== wc_of(i) + 1) begin miscompares++; $display("FAIL b2b_first[%0d] got %0d want %0d", i, t[0], wc_of(i) + 1); end
        vec++; if (t[1] - t[0] !== wc_of(i) + 2) begin miscompares++; $display("FAIL b2b_interval[%0d] got %0d want %0d", i, t[1] - t[0], wc_of(i) + 2); end
        vec++; if (dv[0] !== (32'hB2B00000 | 32'(i))) begin miscompares++; $display("FAIL b2b_data0[%0d] got %h want %h", i, dv[0], 32'hB2B00000 | 32'(i)); end
        vec++; if (dv[1] !== (32'hB2B10000 | 32'(i))) begin miscompares++; $display("FAIL b2b_data1[%0d] got %h want %h", i, dv[1], 32'hB2B10000 | 32'(i)); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] q; logic e; logic saw;
        access(1, 1'b0, 1'b1, 32'h40, 32'h12345678, 4'hF, lat, q, e);
        @(negedge clk);
        wr[1] = 1'b1; ad[1] = 32'h40; di[1] = 32'hCAFEF00D; st[1] = 4'hF;
        @(posedge clk); #1;
        vec++; if (bsy[1] !== 1'b1) begin miscompares++; $display("FAIL mid_busy_wait got %b want 1", bsy[1]); end
        @(negedge clk);
        reset = 1'b1; wr[1] = 1'b0;
        @(posedge clk); #1;
        vec++; if (rdy[1] !== 1'b0) begin miscompares++; $display("FAIL mid_ready got %b want 0", rdy[1]); end
        vec++; if (bsy[1] !== 1'b0) begin miscompares++; $display("FAIL mid_busy got %b want 0", bsy[1]); end
        @(negedge clk);
        reset = 1'b0;
        saw = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (rdy[1]) saw = 1'b1;
        end
        vec++; if (saw !== 1'b0) begin miscompares++; $display("FAIL mid_late_ready got %b want 0", saw); end
        access(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, lat, q, e);
        vec++; if (q !== 32'h12345678) begin miscompares++; $display("FAIL mid_no_commit got %h want 12345678", q); end
    endtask

    task automatic test_reset_idle();
        int lat; logic [31:0] q; logic e;
        access(0, 1'b0, 1'b1, 32'h50, 32'h50505050, 4'hF, lat, q, e);
        @(negedge clk);
        reset = 1'b1; wr[0] = 1'b1; ad[0] = 32'h50; di[0] = 32'hFFFF0000; st[0] = 4'hF;
        @(posedge clk); #1;
        vec++; if (bsy[0] !== 1'b0) begin miscompares++; $display("FAIL idle_rst_busy got %b want 0", bsy[0]); end
        vec++; if (rdy[0] !== 1'b0) begin miscompares++; $display("FAIL idle_rst_ready got %b want 0", rdy[0]); end
        @(negedge clk);
        reset = 1'b0; wr[0] = 1'b0;
        access(0, 1'b1, 1'b0, 32'h50, 32'h0, 4'h0, lat, q, e);
        vec++; if (q !== 32'h50505050) begin miscompares++; $display("FAIL idle_rst_data got %h want 50505050", q); end
    endtask

    task automatic test_changed_addr();
        int lat; logic [31:0] q; logic e;
        access(2, 1'b0, 1'b1, 32'h10, 32'h0A0A0010, 4'hF, lat, q, e);
        access(2, 1'b0, 1'b1, 32'h20, 32'h0B0B0020, 4'hF, lat, q, e);
        @(negedge clk);
        rd[2] = 1'b1; ad[2] = 32'h10;
        @(posedge clk); #1;
        ad[2] = 32'h20;
        lat = 0; q = 32'd0;
        for (int n = 2; n <= 20; n++) begin
            @(posedge clk); #1;
            if (rdy[2]) begin lat = n; q = dout[2]; break; end
        end
        rd[2] = 1'b0;
        @(negedge clk);
        vec++; if (lat !== 5) begin miscompares++; $display("FAIL chg_latency got %0d want 5", lat); end
        vec++; if (q !== 32'h0A0A0010) begin miscompares++; $display("FAIL chg_addr_data got %h want 0a0a0010", q); end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = 32'd0; di[i] = 32'd0; st[i] = 4'd0;
        end
        test_reset();
        for (int i = 0; i < 3; i++) test_latency(i);
        test_strobes();
        test_errors();
        for (int i = 0; i < 3; i++) test_back_to_back(i);
        test_reset_mid();
        test_reset_idle();
        test_changed_addr();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the RV32 in-order pipeline: the target end of the mem-stage load/store request interface.
- Accepts one read or write request at a time from the memory stage.
- Inserts a programmable number of wait states, then returns a single-cycle mem_ready pulse with read data or an error flag.
- Word storage is internal, with byte-lane write strobes.

Parameters:
DEPTH, 1024, number of 32-bit words stored; legal byte addresses 0 .. DEPTH*4-1
WAIT_CYCLES, 1, wait states between request acceptance and response (0..15)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
mem_read_enable  input  1  read request, held by initiator until mem_ready
mem_write_enable  input  1  write request, held by initiator until mem_ready
mem_addr  input  32  byte address of request
mem_data_in  input  32  write data, lane-aligned (byte k on bits 8k+7:8k)
mem_wstrb  input  4  byte-lane write enables; ignored for reads
mem_data_out  output  32  read data, valid while mem_ready=1
mem_ready  output  1  one-cycle response pulse
mem_error  output  1  qualified by mem_ready; request was rejected
busy  output  1  high from acceptance until the response cycle inclusive

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, mem_ready=0, mem_error=0, busy=0, mem_data_out=0, wait counter=0. Storage array is not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If mem_read_enable|mem_write_enable, capture addr, wdata, wstrb, rd, wr.
  - Go to WAIT with counter=WAIT_CYCLES-1, or directly to RESP if WAIT_CYCLES=0.
  - busy rises the cycle after acceptance.
- WAIT: decrement counter; when counter==0, go to RESP. Changes on the request inputs after acceptance are ignored.
- Commit/read edge: the clock edge entering RESP.
  - Write: byte lanes with wstrb[k]=1 updated; other lanes unchanged.
  - Read: mem_data_out loaded from the addressed word.
- RESP: mem_ready=1 and mem_error valid for exactly one cycle; next state is IDLE unconditionally.
- Back-to-back requests: a request still asserted in the first IDLE cycle after RESP is accepted as a new request. The initiator must deassert in the RESP cycle if it has no further request.
- Latency: a request accepted in cycle T gets mem_ready in cycle T+1+WAIT_CYCLES. Minimum throughput is one access per WAIT_CYCLES+2 cycles.
- Error conditions (mem_error=1 in RESP, storage unchanged, mem_data_out=0):
  - addr[1:0]!=0
  - addr >= DEPTH*4
  - rd and wr both asserted at acceptance
  - wr with wstrb==0 is not an error: it is a no-op write that completes normally.
- mem_data_out holds its last value after RESP until the next read/error response. A write response leaves it unchanged.
- mem_error is 0 whenever mem_ready=0.
- Word index = addr[$clog2(DEPTH)+1:2].
- Reset asserted in WAIT or RESP aborts the access: no write commit if reset coincides with the commit edge, no mem_ready pulse. The next cycle is IDLE.
- Simultaneous reset and new request in IDLE: reset wins; the request is not captured.

Test Plan:
- WAIT_CYCLES=1: write addr 0x10, data 0xDEADBEEF, wstrb 4'hF at cycle 0 -> mem_ready=1 at cycle 2, mem_error=0. Read 0x10 -> mem_data_out=0xDEADBEEF with mem_ready at T+2.
- Byte strobes: word 0x20 = 0x11223344, then write 0xAABBCCDD with wstrb 4'b0101 -> read returns 0x11BB33DD.
- Errors:
  - Read addr 0x13 -> mem_ready with mem_error=1, mem_data_out=0.
  - Write addr DEPTH*4 -> mem_error=1, no word modified (verify by reading 0x0).
  - rd=wr=1 -> mem_error=1.
- Latency sweep: WAIT_CYCLES=0, 1, 4 -> mem_ready exactly 1, 2, 5 cycles after acceptance. Held back-to-back reads complete every WAIT_CYCLES+2 cycles with correct data.
- Reset mid-operation: write 0xCAFEF00D to 0x40, assert reset in WAIT -> no mem_ready, busy=0 next cycle; a read of 0x40 returns its prior value.
- Request changed during WAIT (addr switched 0x10->0x20) -> response uses captured addr 0x10.
